// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone classic slave with a small word-addressed register memory,
// programmable wait states and byte lanes. Define WB_SLAVE_ERR_EN to answer misses with s_err_o.
`ifndef WB_AW
`define WB_AW 32
`endif
`ifndef WB_DW
`define WB_DW 32
`endif
`ifndef WB_SELW
`define WB_SELW 4
`endif

module wb_slave_mem #(
  parameter logic [`WB_AW-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_cyc_i,
  input  logic                  s_stb_i,
  input  logic                  s_we_i,
  input  logic [`WB_AW-1:0]     s_addr_i,
  input  logic [`WB_SELW-1:0]   s_sel_i,
  input  logic [`WB_DW-1:0]     s_data_i,
  output logic [`WB_DW-1:0]     s_data_o,
  output logic                  s_ack_o,
  output logic                  s_err_o
);
  localparam int AW   = `WB_AW;
  localparam int DW   = `WB_DW;
  localparam int SELW = `WB_SELW;
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer is requested while s_cyc_i & s_stb_i is high at a rising edge;
  // it completes with exactly one cycle of s_ack_o (or s_err_o) and the master must drop
  // s_stb_i on the edge that samples it. Dropping the request during WAIT aborts it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
`ifdef WB_SLAVE_ERR_EN
    S_ERR  = 2'd3,
`endif
    S_ACK  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  state_e          done_state;
  logic [3:0]      cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   mem_d [DEPTH];

  logic            req;
  logic            hit;
  logic            commit;
  logic [AW-1:0]   offset;
  logic [IDXW-1:0] idx;

  assign req    = s_cyc_i & s_stb_i;
  assign offset = s_addr_i - BASE_ADDR;
  // Extra bit keeps the range check correct when DEPTH equals 2**AW.
  assign hit    = (s_addr_i >= BASE_ADDR) && ({1'b0, offset} < (AW+1)'(DEPTH));
  assign idx    = offset[IDXW-1:0];

`ifdef WB_SLAVE_ERR_EN
  assign done_state = hit ? S_ACK : S_ERR;
`else
  assign done_state = S_ACK;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = done_state;
            commit  = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = done_state;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Commit uses the live bus inputs on the edge that enters ACK.
  always_comb begin
    mem_d  = mem_q;
    data_d = data_q;
    if (commit) begin
      if (s_we_i) begin
        if (hit) begin
          for (int k = 0; k < SELW; k++) begin
            if (s_sel_i[k]) mem_d[idx][8*k +: 8] = s_data_i[8*k +: 8];
          end
        end
      end else begin
`ifdef WB_SLAVE_ERR_EN
        if (hit) data_d = mem_q[idx];
`else
        data_d = hit ? mem_q[idx] : '0;
`endif
      end
    end
    ack_d = (state_d == S_ACK);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      mem_q   <= mem_d;
    end
  end

`ifdef WB_SLAVE_ERR_EN
  logic err_q, err_d;
  assign err_d = (state_d == S_ERR);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign s_err_o = err_q;
`else
  assign s_err_o = 1'b0;
`endif

  assign s_ack_o  = ack_q;
  assign s_data_o = data_q;

endmodule
